// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter
//   Packet-level round-robin multiplexer that shares one AXI-Stream output
//   among S_COUNT input streams. A grant is taken in IDLE and held for a whole
//   packet, until the beat that carries tlast is accepted. The arbiter then
//   returns to IDLE for one cycle before it picks the next input.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   s_id_i/s_data_i/s_user_i  packed input fields, stream k at [k*W +: W]
//   s_last_i/s_valid_i  input tlast/tvalid, bit k = stream k
//   s_ready_o           input tready, one-hot on the granted stream only
//   m_id_o/m_data_o/m_user_o/m_last_o/m_valid_o  fields of the granted stream
//   m_ready_i           output tready
//   m_sel_o             index of the granted stream
//   busy_o              1 while a packet grant is held (state is PASS)
//
// Handshake: a beat moves when valid and ready are both high on a rising
// clk edge. m_valid_o never depends on m_ready_i; s_ready_o is m_ready_i
// routed to the granted input, so that path is combinational.
module axis_rr_arbiter #(
    parameter  int S_COUNT      = 4,
    parameter  int T_DATA_WIDTH = 8,
    parameter  int T_USER_WIDTH = 10,
    parameter  int T_ID_WIDTH   = 8,
    localparam int SW           = $clog2(S_COUNT)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [S_COUNT*T_ID_WIDTH-1:0]    s_id_i,
    input  logic [S_COUNT*T_DATA_WIDTH-1:0]  s_data_i,
    input  logic [S_COUNT*T_USER_WIDTH-1:0]  s_user_i,
    input  logic [S_COUNT-1:0]               s_last_i,
    input  logic [S_COUNT-1:0]               s_valid_i,
    output logic [S_COUNT-1:0]               s_ready_o,
    output logic [T_ID_WIDTH-1:0]            m_id_o,
    output logic [T_DATA_WIDTH-1:0]          m_data_o,
    output logic [T_USER_WIDTH-1:0]          m_user_o,
    output logic                             m_last_o,
    output logic                             m_valid_o,
    input  logic                             m_ready_i,
    output logic [SW-1:0]                    m_sel_o,
    output logic                             busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    state_t        state_q;
    logic [SW-1:0] sel_q;
    logic [SW-1:0] prio_q;
    logic          busy_q;

    logic [SW-1:0] grant_d;
    logic          grant_found;
    logic [SW-1:0] idx;
    logic          hs;

    // Search starts one past the last granted input and wraps at S_COUNT,
    // so indices >= S_COUNT are never visited for non-power-of-2 counts.
    always_comb begin
        grant_found = 1'b0;
        grant_d     = '0;
        idx         = prio_q;
        for (int i = 0; i < S_COUNT; i++) begin
            idx = (idx == SW'(S_COUNT - 1)) ? '0 : idx + 1'b1;
            if (!grant_found && s_valid_i[idx]) begin
                grant_found = 1'b1;
                grant_d     = idx;
            end
        end
    end

    // Zero-latency field mux; in IDLE these show stream sel_q but valid is 0.
    assign m_id_o    = s_id_i[sel_q*T_ID_WIDTH +: T_ID_WIDTH];
    assign m_data_o  = s_data_i[sel_q*T_DATA_WIDTH +: T_DATA_WIDTH];
    assign m_user_o  = s_user_i[sel_q*T_USER_WIDTH +: T_USER_WIDTH];
    assign m_last_o  = s_last_i[sel_q];
    assign m_valid_o = (state_q == PASS) & s_valid_i[sel_q];
    assign m_sel_o   = sel_q;
    assign busy_o    = busy_q;
    assign hs        = m_valid_o & m_ready_i;

    always_comb begin
        s_ready_o = '0;
        if (state_q == PASS && m_ready_i) begin
            s_ready_o[sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            prio_q  <= SW'(S_COUNT - 1);
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        sel_q   <= grant_d;
                        state_q <= PASS;
                        busy_q  <= 1'b1;
                    end
                end
                PASS: begin
                    // Grant is held through valid gaps; only an accepted
                    // last beat releases it.
                    if (hs && m_last_o) begin
                        prio_q  <= sel_q;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
module tb_axis_rr_arbiter;

    localparam int S  = 4;
    localparam int IW = 8;
    localparam int DW = 8;
    localparam int UW = 10;
    localparam int BW = 1 + IW + DW + UW + 1;  // {gap, id, data, user, last}
    localparam int EW = 2 + IW + DW + UW + 1;  // {sel, id, data, user, last}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (S_COUNT=4) ----------------
    logic [S*IW-1:0] s_id_i;
    logic [S*DW-1:0] s_data_i;
    logic [S*UW-1:0] s_user_i;
    logic [S-1:0]    s_last_i;
    logic [S-1:0]    s_valid_i;
    logic [S-1:0]    s_ready_o;
    logic [IW-1:0]   m_id_o;
    logic [DW-1:0]   m_data_o;
    logic [UW-1:0]   m_user_o;
    logic            m_last_o;
    logic            m_valid_o;
    logic            m_ready_i = 1'b0;
    logic [1:0]      m_sel_o;
    logic            busy_o;

    axis_rr_arbiter #(.S_COUNT(S), .T_DATA_WIDTH(DW), .T_USER_WIDTH(UW), .T_ID_WIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .s_id_i(s_id_i), .s_data_i(s_data_i), .s_user_i(s_user_i),
        .s_last_i(s_last_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m_id_o(m_id_o), .m_data_o(m_data_o), .m_user_o(m_user_o),
        .m_last_o(m_last_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_sel_o(m_sel_o), .busy_o(busy_o)
    );

    // ---------------- second DUT (S_COUNT=3, wrap case) ----------------
    logic          d3_reset = 1'b1;
    logic [23:0]   d3_id    = '0;
    logic [23:0]   d3_data  = {8'hC2, 8'hC1, 8'hC0};
    logic [29:0]   d3_user  = '0;
    logic [2:0]    d3_last  = 3'b111;
    logic [2:0]    d3_valid = '0;
    logic [2:0]    d3_ready;
    logic [7:0]    d3_m_id;
    logic [7:0]    d3_m_data;
    logic [9:0]    d3_m_user;
    logic          d3_m_last;
    logic          d3_m_valid;
    logic          d3_m_ready = 1'b1;
    logic [1:0]    d3_sel;
    logic          d3_busy;

    axis_rr_arbiter #(.S_COUNT(3), .T_DATA_WIDTH(8), .T_USER_WIDTH(10), .T_ID_WIDTH(8)) dut3 (
        .clk(clk), .reset(d3_reset),
        .s_id_i(d3_id), .s_data_i(d3_data), .s_user_i(d3_user),
        .s_last_i(d3_last), .s_valid_i(d3_valid), .s_ready_o(d3_ready),
        .m_id_o(d3_m_id), .m_data_o(d3_m_data), .m_user_o(d3_m_user),
        .m_last_o(d3_m_last), .m_valid_o(d3_m_valid), .m_ready_i(d3_m_ready),
        .m_sel_o(d3_sel), .busy_o(d3_busy)
    );

    // ---------------- scoreboard state ----------------
    logic [BW-1:0] src_q[S][$];
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Push one packet for input k into its source queue and the matching
    // output beats into the expected queue. Three invalid cycles follow
    // beat gap_at when gap_at >= 0.
    task automatic send_pkt(input int k, input int n, input int tag, input int gap_at);
        logic [IW-1:0] id;
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic          l;
        for (int i = 0; i < n; i++) begin
            id = IW'(k * 16 + tag);
            d  = DW'(tag * 16 + i);
            u  = UW'(k * 64 + i);
            l  = (i == n - 1);
            src_q[k].push_back({1'b0, id, d, u, l});
            exp_q.push_back({2'(k), id, d, u, l});
            if (i == gap_at) begin
                repeat (3) src_q[k].push_back({1'b1, {(BW-1){1'b0}}});
            end
        end
    endtask

    // ---------------- source driver ----------------
    logic [S-1:0]  fire;
    logic [S-1:0]  cur_gap;
    logic [BW-1:0] beat;

    initial begin
        s_id_i = '0; s_data_i = '0; s_user_i = '0; s_last_i = '0; s_valid_i = '0;
        cur_gap = '0;
        forever begin
            @(negedge clk);
            fire = s_valid_i & s_ready_o;
            @(posedge clk);
            #1;
            for (int k = 0; k < S; k++) begin
                if ((fire[k] || cur_gap[k]) && src_q[k].size() > 0) begin
                    void'(src_q[k].pop_front());
                end
                if (src_q[k].size() > 0) begin
                    beat = src_q[k][0];
                    cur_gap[k]           = beat[BW-1];
                    s_valid_i[k]         = !beat[BW-1];
                    s_id_i[k*IW +: IW]   = beat[BW-2 -: IW];
                    s_data_i[k*DW +: DW] = beat[BW-2-IW -: DW];
                    s_user_i[k*UW +: UW] = beat[UW:1];
                    s_last_i[k]          = beat[0];
                end else begin
                    cur_gap[k]   = 1'b0;
                    s_valid_i[k] = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic          chk_bubble;
    logic [EW-1:0] e;
    logic [S-1:0]  exp_rdy;

    initial begin
        chk_bubble = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk_bubble = 1'b0;
            end else begin
                if (chk_bubble) begin
                    check("bubble_busy", busy_o, 0);
                    check("bubble_valid", m_valid_o, 0);
                    chk_bubble = 1'b0;
                end
                if (busy_o && exp_q.size() > 0) begin
                    e = exp_q[0];
                    exp_rdy = m_ready_i ? (S'(1) << e[EW-1 -: 2]) : '0;
                    check("s_ready", s_ready_o, exp_rdy);
                end
                if (m_valid_o && m_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat actual=%0h expected=none",
                                 {m_sel_o, m_id_o, m_data_o, m_user_o, m_last_o});
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {m_sel_o, m_id_o, m_data_o, m_user_o, m_last_o}, e);
                        if (e[0]) chk_bubble = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        reset = 1'b1;
        m_ready_i = 1'b0;
        for (int k = 0; k < S; k++) src_q[k].delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        check("reset_busy", busy_o, 0);
        check("reset_valid", m_valid_o, 0);
        check("reset_sel", m_sel_o, 0);
        check("reset_ready", s_ready_o, 0);
        reset = 1'b0;
        m_ready_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_drain(input int bound);
        for (int c = 0; c < bound && exp_q.size() > 0; c++) @(posedge clk);
        check("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // ---------------- directed tests ----------------
    initial begin
        // Test 1: single requester on input 2, one-cycle arbitration latency.
        do_reset();
        send_pkt(2, 3, 1, -1);
        @(posedge clk); #2;
        check("t1_idle_busy", busy_o, 0);
        check("t1_idle_valid", m_valid_o, 0);
        @(posedge clk); #2;
        check("t1_sel", m_sel_o, 2);
        check("t1_valid", m_valid_o, 1);
        check("t1_ready", s_ready_o, 4'b0100);
        wait_drain(50);

        // Test 2: all inputs busy, two packets each -> grants 0,1,2,3,0,1,2,3.
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < S; k++) send_pkt(k, 2, 2 + p, -1);
        wait_drain(200);

        // Test 3: input 1 drops valid for 3 cycles mid-packet while input 3 waits.
        do_reset();
        send_pkt(1, 3, 4, 1);
        send_pkt(3, 2, 4, -1);
        wait_drain(100);

        // Test 4: m_ready_i toggles every cycle during an 8-beat packet.
        do_reset();
        send_pkt(2, 8, 7, -1);
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            @(posedge clk); #1;
            m_ready_i = ~m_ready_i;
        end
        m_ready_i = 1'b1;
        check("t4_drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);

        // Test 5: reset during beat 2 of a 4-beat packet, then single-beat
        // packets from inputs 1 and 3 -> lowest valid index first.
        do_reset();
        send_pkt(0, 4, 5, -1);
        for (int c = 0; c < 100 && exp_q.size() > 2; c++) begin
            @(posedge clk); #1;
        end
        check("t5_two_beats", exp_q.size(), 2);
        m_ready_i = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < S; k++) src_q[k].delete();
        exp_q.delete();
        @(posedge clk); #2;
        check("t5_valid", m_valid_o, 0);
        check("t5_ready", s_ready_o, 0);
        check("t5_busy", busy_o, 0);
        reset = 1'b0;
        m_ready_i = 1'b1;
        @(negedge clk);
        send_pkt(1, 1, 6, -1);
        send_pkt(3, 1, 6, -1);
        wait_drain(50);

        // Test 6: S_COUNT=3, pointer at 2 after reset.
        d3_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        d3_reset = 1'b0;
        d3_valid = 3'b101;
        @(posedge clk); #1;
        check("t6_sel_wrap", d3_sel, 0);
        check("t6_busy", d3_busy, 1);
        check("t6_data0", d3_m_data, 8'hC0);
        check("t6_ready0", d3_ready, 3'b001);
        @(posedge clk); #1;
        check("t6_idle", d3_busy, 0);
        d3_valid = 3'b100;
        @(posedge clk); #1;
        check("t6_sel2", d3_sel, 2);
        check("t6_data2", d3_m_data, 8'hC2);
        check("t6_ready2", d3_ready, 3'b100);
        d3_valid = 3'b111;
        @(posedge clk); #1;
        check("t6_idle2", d3_busy, 0);
        @(posedge clk); #1;
        check("t6_sel_wrap2", d3_sel, 0);
        d3_valid = 3'b000;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
